// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer: pulses the PLL reset, qualifies lock,
// retries on timeout and holds the downstream reset until lock is stable.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic       lol_sticky
);

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lol_q, lol_d;
  logic               sync1_q, sync2_q;
  logic               locked_s;
  logic               pll_rst_q, sys_rst_n_q, ready_q, fault_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // Next-state, counter, retry and sticky-flag logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    lol_d   = lol_q & ~clear_status;

    case (state_q)
      RST_PLL: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_d = '0;
          if (retry_q == RETRY_W'(MAX_RETRIES)) begin
            state_d = FAULT;
          end else begin
            state_d = RST_PLL;
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = RST_PLL;
          retry_d = '0;
          lol_d   = 1'b1;
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase

    // Restart overrides every transition but leaves a same-cycle loss flag set
    if (restart) begin
      state_d = RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // State, counter and outputs decoded from the next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lol_q       <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      pll_rst_q   <= (state_d == RST_PLL) || (state_d == FAULT);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lol_sticky  = lol_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues cycle-stamped
// expected output vectors, a monitor pops and compares them each cycle.
module tb_pll_lock_sequencer;

  localparam int unsigned RST_P = 4;
  localparam int unsigned TO    = 20;
  localparam int unsigned ST    = 8;
  localparam int unsigned MR    = 2;
  localparam int unsigned CW    = 16;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic       lol_sticky;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RST_P),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST),
    .MAX_RETRIES        (MR),
    .CNT_W              (CW)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .lol_sticky  (lol_sticky)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  // Expected vector: {pll_rst, sys_rst_n, ready, fault, retry_count, lol_sticky}
  typedef struct {
    int         cyc;
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_at(input int off, input string name, input logic pr,
                           input logic srn, input logic rdy, input logic flt,
                           input logic [3:0] rc, input logic lol);
    exp_t e;
    int   i;
    e.cyc  = cyc + off;
    e.v    = {pr, srn, rdy, flt, rc, lol};
    e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic nstep(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Monitor: compare every expectation due at or before the current cycle
  initial begin
    forever begin
      @(negedge refclk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t       e;
        logic [8:0] got;
        e   = sb.pop_front();
        got = {pll_rst, sys_rst_n, ready, fault, retry_count, lol_sticky};
        checks++;
        if (e.cyc != cyc || got !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got=%b exp=%b (pr,srn,rdy,flt,rc[4],lol)",
                   e.name, cyc, e.cyc, got, e.v);
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    restart      = 1'b0;
    clear_status = 1'b0;
    nstep(3);

    // T1: lock 5 cycles after pll_rst falls, qualify, reach RUN
    rst_n = 1'b1;
    expect_at(0,  "t1_reset_vals", 1, 0, 0, 0, 0, 0);
    expect_at(3,  "t1_prst_hi",    1, 0, 0, 0, 0, 0);
    expect_at(4,  "t1_prst_lo",    0, 0, 0, 0, 0, 0);
    nstep(9);
    pll_locked = 1'b1;
    expect_at(10, "t1_not_run",    0, 0, 0, 0, 0, 0);
    expect_at(11, "t1_run",        0, 1, 1, 0, 0, 0);
    nstep(13);

    // T4: loss of lock in RUN, re-lock, then set-vs-clear collision
    pll_locked = 1'b0;
    expect_at(2, "t4_still_run",   0, 1, 1, 0, 0, 0);
    expect_at(3, "t4_lol_set",     1, 0, 0, 0, 0, 1);
    expect_at(6, "t4_prst_hold",   1, 0, 0, 0, 0, 1);
    expect_at(7, "t4_prst_lo",     0, 0, 0, 0, 0, 1);
    nstep(7);
    pll_locked = 1'b1;
    expect_at(10, "t4_relock_wait", 0, 0, 0, 0, 0, 1);
    expect_at(11, "t4_relock_run",  0, 1, 1, 0, 0, 1);
    nstep(13);
    pll_locked = 1'b0;
    expect_at(2, "t4_run2",        0, 1, 1, 0, 0, 1);
    expect_at(3, "t4_set_wins",    1, 0, 0, 0, 0, 1);
    expect_at(5, "t4_lone_clear",  1, 0, 0, 0, 0, 0);
    expect_at(6, "t4_prst_hold2",  1, 0, 0, 0, 0, 0);
    expect_at(7, "t4_prst_lo2",    0, 0, 0, 0, 0, 0);
    nstep(2);
    clear_status = 1'b1;
    nstep(1);
    clear_status = 1'b0;
    nstep(1);
    clear_status = 1'b1;
    nstep(1);
    clear_status = 1'b0;
    nstep(3);

    // T3: one-cycle drop in STABLE restarts qualification
    pll_locked = 1'b1;
    expect_at(11, "t3_no_early_run", 0, 0, 0, 0, 0, 0);
    expect_at(16, "t3_not_yet_run",  0, 0, 0, 0, 0, 0);
    expect_at(17, "t3_run",          0, 1, 1, 0, 0, 0);
    nstep(5);
    pll_locked = 1'b0;
    nstep(1);
    pll_locked = 1'b1;
    nstep(15);

    // T6: restart coinciding with loss of lock in RUN
    pll_locked = 1'b0;
    expect_at(2, "t6_still_run",   0, 1, 1, 0, 0, 0);
    expect_at(3, "t6_restart_lol", 1, 0, 0, 0, 0, 1);
    expect_at(6, "t6_prst_hold",   1, 0, 0, 0, 0, 1);
    expect_at(7, "t6_prst_lo",     0, 0, 0, 0, 0, 1);
    nstep(2);
    restart = 1'b1;
    nstep(1);
    restart = 1'b0;
    nstep(6);

    // T2: no lock -> retries, FAULT, then restart
    rst_n = 1'b0;
    nstep(2);
    rst_n = 1'b1;
    expect_at(0,  "t2_reset_vals",  1, 0, 0, 0, 0, 0);
    expect_at(3,  "t2_p1_hi",       1, 0, 0, 0, 0, 0);
    expect_at(4,  "t2_p1_lo",       0, 0, 0, 0, 0, 0);
    expect_at(23, "t2_wait1_end",   0, 0, 0, 0, 0, 0);
    expect_at(24, "t2_p2_start",    1, 0, 0, 0, 1, 0);
    expect_at(27, "t2_p2_hi",       1, 0, 0, 0, 1, 0);
    expect_at(28, "t2_p2_lo",       0, 0, 0, 0, 1, 0);
    expect_at(47, "t2_wait2_end",   0, 0, 0, 0, 1, 0);
    expect_at(48, "t2_p3_start",    1, 0, 0, 0, 2, 0);
    expect_at(51, "t2_p3_hi",       1, 0, 0, 0, 2, 0);
    expect_at(52, "t2_p3_lo",       0, 0, 0, 0, 2, 0);
    expect_at(71, "t2_wait3_end",   0, 0, 0, 0, 2, 0);
    expect_at(72, "t2_fault",       1, 0, 0, 1, 2, 0);
    expect_at(80, "t2_fault_hold",  1, 0, 0, 1, 2, 0);
    nstep(80);
    restart = 1'b1;
    expect_at(1, "t2_restart",      1, 0, 0, 0, 0, 0);
    expect_at(4, "t2_rp_hi",        1, 0, 0, 0, 0, 0);
    expect_at(5, "t2_rp_lo",        0, 0, 0, 0, 0, 0);
    expect_at(24, "t2_retry_again", 0, 0, 0, 0, 0, 0);
    expect_at(25, "t2_retry1",      1, 0, 0, 0, 1, 0);
    expect_at(29, "t2_wait_r1",     0, 0, 0, 0, 1, 0);
    expect_at(32, "t5_pre_reset",   0, 0, 0, 0, 1, 0);
    nstep(1);
    restart = 1'b0;
    nstep(31);

    // T5: asynchronous reset in WAIT_LOCK with retry_count=1
    @(posedge refclk);
    #1;
    rst_n = 1'b0;
    expect_at(0, "t5_async_reset",  1, 0, 0, 0, 0, 0);
    nstep(3);
    rst_n = 1'b1;
    expect_at(0, "t5_release",      1, 0, 0, 0, 0, 0);
    expect_at(3, "t5_rp_hi",        1, 0, 0, 0, 0, 0);
    expect_at(4, "t5_rp_lo",        0, 0, 0, 0, 0, 0);
    nstep(6);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      nstep(1);
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
